// File: rtl/heap_mover.sv
// heap_mover: small DMA-style engine that fills or copies bytes inside an
// external 32 x 8-bit heap.
//
// Ports
//   CLK, RST          single clock, synchronous active-high reset
//   START, OP         command strobe (sampled in idle only), 0 = FILL, 1 = COPY
//   SRC, DST, LEN     copy source base, destination base, byte count (0..32, larger clamps)
//   FILL_VAL          data byte for FILL
//   BUSY, DONE        command in progress / one-cycle completion pulse
//   cWR, cADDR,       CPU-side heap access; passed through to the heap while the
//   ciData, cData     engine is idle, CPU writes dropped while it is busy
//   hWR, hADDR,       heap port; hoData is combinational from hADDR
//   hiData, hoData
module heap_mover (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       OP,
    input  logic [4:0] SRC,
    input  logic [4:0] DST,
    input  logic [5:0] LEN,
    input  logic [7:0] FILL_VAL,
    output logic       BUSY,
    output logic       DONE,
    input  logic       cWR,
    input  logic [4:0] cADDR,
    input  logic [7:0] ciData,
    output logic [7:0] cData,
    output logic       hWR,
    output logic [4:0] hADDR,
    output logic [7:0] hiData,
    input  logic [7:0] hoData
);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StCpRd,
        StCpWr,
        StFin
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] count_q, count_d;
    logic [4:0] src_q, src_d;
    logic [4:0] dst_q, dst_d;
    logic [7:0] fill_q, fill_d;
    logic [7:0] buf_q, buf_d;

    logic [5:0] len_clamped;
    logic       last_byte;

    // Counts above the heap size are clamped so one command never laps the heap.
    assign len_clamped = (LEN > 6'd32) ? 6'd32 : LEN;
    // The byte handled this cycle is the final one of the command.
    assign last_byte   = (count_q <= 6'd1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            count_q <= 6'd0;
            src_q   <= 5'd0;
            dst_q   <= 5'd0;
            fill_q  <= 8'd0;
            buf_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (START) begin
                    if (len_clamped == 6'd0) begin
                        state_d = StFin;
                    end else if (OP) begin
                        state_d = StCpRd;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (last_byte) begin
                    state_d = StFin;
                end
            end
            StCpRd: begin
                state_d = StCpWr;
            end
            StCpWr: begin
                state_d = last_byte ? StFin : StCpRd;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: command capture, pointer/count stepping
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        src_d   = src_q;
        dst_d   = dst_q;
        fill_d  = fill_q;
        buf_d   = buf_q;
        case (state_q)
            StIdle: begin
                if (START) begin
                    count_d = len_clamped;
                    src_d   = SRC;
                    dst_d   = DST;
                    fill_d  = FILL_VAL;
                end
            end
            StFill: begin
                // 5-bit pointers wrap 31 -> 0 naturally.
                dst_d   = dst_q + 5'd1;
                count_d = count_q - 6'd1;
            end
            StCpRd: begin
                buf_d = hoData;
            end
            StCpWr: begin
                src_d   = src_q + 5'd1;
                dst_d   = dst_q + 5'd1;
                count_d = count_q - 6'd1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: status and heap port mux
    // ------------------------------------------------------------------
    always_comb begin
        BUSY   = 1'b0;
        DONE   = 1'b0;
        hWR    = 1'b0;
        hADDR  = cADDR;
        hiData = ciData;
        case (state_q)
            StFill: begin
                BUSY   = 1'b1;
                hWR    = ~RST;
                hADDR  = dst_q;
                hiData = fill_q;
            end
            StCpRd: begin
                BUSY   = 1'b1;
                hWR    = 1'b0;
                hADDR  = src_q;
                hiData = buf_q;
            end
            StCpWr: begin
                BUSY   = 1'b1;
                hWR    = ~RST;
                hADDR  = dst_q;
                hiData = buf_q;
            end
            StFin: begin
                DONE = 1'b1;
                hWR  = cWR & ~RST;
            end
            default: begin
                // Idle: CPU owns the heap; reset still blocks its writes.
                hWR = cWR & ~RST;
            end
        endcase
    end

    // CPU reads always see the heap; while busy that is the engine's address.
    assign cData = hoData;

endmodule
